// File: rtl/led_page_sequencer_pkg.sv
// Shared page and state constants for the LED page sequencer.
// Also provides the page-advance helper used by the top module.
package led_seq_pkg;

    localparam logic [2:0] PAGE_B0    = 3'd0;
    localparam logic [2:0] PAGE_B1    = 3'd1;
    localparam logic [2:0] PAGE_B2    = 3'd2;
    localparam logic [2:0] PAGE_B3    = 3'd3;
    localparam logic [2:0] PAGE_FLAGS = 3'd4;
    localparam logic [2:0] PAGE_LAST  = 3'd4;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_e;

    function automatic logic [2:0] next_page(input logic [2:0] p);
        return (p >= PAGE_LAST) ? PAGE_B0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/led_page_sequencer_if.sv
// CPU-side and display-side signals of the LED page sequencer.
// master drives the datapath/button inputs, slave is the sequencer.
interface led_seq_if;

    logic [31:0] dina;
    logic        ofa;
    logic        zfa;
    logic        cap;
    logic        auto_en;
    logic        btn_next;
    logic [31:0] dout;
    logic        of_out;
    logic        zf_out;
    logic [2:0]  sela;
    logic        cap_ack;

    modport master (
        output dina, ofa, zfa, cap, auto_en, btn_next,
        input  dout, of_out, zf_out, sela, cap_ack
    );

    modport slave (
        input  dina, ofa, zfa, cap, auto_en, btn_next,
        output dout, of_out, zf_out, sela, cap_ack
    );

endinterface

// File: rtl/led_page_sequencer_btn_cond.sv
// Push-button conditioner: 2-flop sync, optional debounce, press pulse.
// Debounce is compiled in only when LED_SEQ_DEBOUNCE_EN is defined.
module led_btn_cond #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be >= 1");
    end

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEB_CYCLES);

    logic [CW-1:0] r_cnt;

    // Saturates once the press has fired so a long hold gives one pulse.
    always_ff @(posedge clk) begin
        if (rst || !r_s2) begin
            r_cnt <= '0;
        end else if (r_cnt != C_FULL) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_press = r_s2 && (r_cnt == C_LAST);
`else
    logic r_s2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_d <= 1'b0;
        end else begin
            r_s2_d <= r_s2;
        end
    end

    assign o_press = r_s2 & ~r_s2_d;
`endif

endmodule

// File: rtl/led_page_sequencer.sv
// LED page sequencer: snapshots ALU result/flags, scans pages 0..4.
// Button debounce selected by LED_SEQ_DEBOUNCE_EN (see led_btn_cond).
module led_page_sequencer
    import led_seq_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int DEB_CYCLES   = 1_000_000
) (
    input  logic      clk,
    input  logic      rst,
    led_seq_if.slave  bus
);

    if (DWELL_CYCLES < 2) begin : g_bad_dwell
        $error("DWELL_CYCLES must be >= 2");
    end

    localparam int CW = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(DWELL_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]  r_sela;
    logic [2:0]  w_sela_nxt;
    logic [31:0] r_dout;
    logic        r_of;
    logic        r_zf;
    logic        r_ack;
    logic        w_press;
    logic        w_mode_chg;
    logic        w_expire;

    led_btn_cond #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.btn_next),
        .o_press (w_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_MANUAL;
            r_cnt   <= '0;
            r_sela  <= PAGE_B0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sela  <= w_sela_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
            r_of   <= 1'b0;
            r_zf   <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_ack <= bus.cap;
            if (bus.cap) begin
                r_dout <= bus.dina;
                r_of   <= bus.ofa;
                r_zf   <= bus.zfa;
            end
        end
    end

    // Priority: capture, then mode change, then press/expiry.
    always_comb begin
        w_state_nxt = bus.auto_en ? ST_AUTO : ST_MANUAL;
        w_mode_chg  = (w_state_nxt != r_state);
        w_expire    = 1'b0;
        w_cnt_nxt   = '0;
        w_sela_nxt  = r_sela;
        unique case (r_state)
            ST_AUTO: begin
                w_expire  = !w_mode_chg && (r_cnt == C_LAST);
                w_cnt_nxt = r_cnt + CW'(1);
            end
            ST_MANUAL: begin
                w_cnt_nxt = '0;
            end
        endcase
        if (w_press || w_expire) begin
            w_sela_nxt = next_page(r_sela);
            w_cnt_nxt  = '0;
        end
        if (w_mode_chg) begin
            w_cnt_nxt = '0;
        end
        if (bus.cap) begin
            w_sela_nxt = PAGE_B0;
            w_cnt_nxt  = '0;
        end
    end

    assign bus.dout    = r_dout;
    assign bus.of_out  = r_of;
    assign bus.zf_out  = r_zf;
    assign bus.sela    = r_sela;
    assign bus.cap_ack = r_ack;

endmodule

// File: tb/tb_led_page_sequencer.sv
// Scoreboard bench for led_page_sequencer (DWELL=4, DEB=3).
// Behavioural model predicts outputs; a negedge monitor compares.
module tb_led_page_sequencer;

    localparam int DWELL = 4;
    localparam int DEB   = 3;

    typedef struct {
        logic [2:0]  sela;
        logic        ack;
        logic [31:0] d;
        logic        o;
        logic        z;
    } cyc_t;

    typedef struct {
        logic [31:0] d;
        logic        o;
        logic        z;
    } snap_t;

    logic clk = 1'b0;
    logic rst;

    led_seq_if bus();

    led_page_sequencer #(
        .DWELL_CYCLES (DWELL),
        .DEB_CYCLES   (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    cyc_t  exp_q[$];
    snap_t cap_q[$];
    bit    hist[$];
    int    checks = 0;
    int    errors = 0;

    int          m_sela    = 0;
    int          m_elapsed = 0;
    bit          m_auto    = 1'b0;
    logic [31:0] m_d       = '0;
    logic        m_o       = 1'b0;
    logic        m_z       = 1'b0;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     n, act, exp, $time);
        end
    endtask

    // A press is seen from the button's sampled history alone.
    function automatic bit press_at(int k);
`ifdef LED_SEQ_DEBOUNCE_EN
        if (k < DEB + 2) return 1'b0;
        if (hist[k-2-DEB]) return 1'b0;
        for (int j = k - 1 - DEB; j <= k - 2; j++)
            if (!hist[j]) return 1'b0;
        return 1'b1;
`else
        if (k < 3) return 1'b0;
        return hist[k-2] && !hist[k-3];
`endif
    endfunction

    always @(posedge clk) begin : model
        int    k;
        bit    press;
        bit    expire;
        bit    chg;
        cyc_t  c;
        snap_t s;
        k = hist.size();
        hist.push_back(rst ? 1'b0 : bus.btn_next);
        press = press_at(k);
        c.ack = 1'b0;
        if (rst) begin
            m_sela    = 0;
            m_elapsed = 0;
            m_auto    = 1'b0;
            m_d       = '0;
            m_o       = 1'b0;
            m_z       = 1'b0;
        end else begin
            chg   = (bus.auto_en != m_auto);
            c.ack = bus.cap;
            if (bus.cap) begin
                m_d       = bus.dina;
                m_o       = bus.ofa;
                m_z       = bus.zfa;
                m_sela    = 0;
                m_elapsed = 0;
                s.d = m_d;
                s.o = m_o;
                s.z = m_z;
                cap_q.push_back(s);
            end else begin
                expire = m_auto && !chg && (m_elapsed == DWELL - 1);
                if (press || expire) begin
                    m_sela    = (m_sela + 1) % 5;
                    m_elapsed = 0;
                end else if (m_auto && !chg) begin
                    m_elapsed++;
                end else begin
                    m_elapsed = 0;
                end
            end
            m_auto = bus.auto_en;
        end
        c.sela = 3'(m_sela);
        c.d    = m_d;
        c.o    = m_o;
        c.z    = m_z;
        exp_q.push_back(c);
    end

    always @(negedge clk) begin : monitor
        cyc_t  c;
        snap_t s;
        if (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            chk("sela", 32'(bus.sela), 32'(c.sela));
            chk("cap_ack", 32'(bus.cap_ack), 32'(c.ack));
            chk("dout", bus.dout, c.d);
            chk("of_out", 32'(bus.of_out), 32'(c.o));
            chk("zf_out", 32'(bus.zf_out), 32'(c.z));
            if (bus.cap_ack === 1'b1) begin
                checks++;
                if (cap_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: got ack expected none at %0t",
                             $time);
                end else begin
                    s = cap_q.pop_front();
                    chk("ack_dout", bus.dout, s.d);
                    chk("ack_flags", {30'd0, bus.of_out, bus.zf_out},
                        {30'd0, s.o, s.z});
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic capture(logic [31:0] d, logic o, logic z);
        bus.dina = d;
        bus.ofa  = o;
        bus.zfa  = z;
        bus.cap  = 1'b1;
        tick();
        bus.cap  = 1'b0;
    endtask

    initial begin : stim
        int run;
        rst          = 1'b1;
        bus.cap      = 1'b1;
        bus.btn_next = 1'b1;
        bus.auto_en  = 1'b0;
        bus.dina     = 32'hDEAD_BEEF;
        bus.ofa      = 1'b1;
        bus.zfa      = 1'b1;
        tick(2);
        rst          = 1'b0;
        bus.cap      = 1'b0;
        bus.btn_next = 1'b0;
        tick(6);

        capture(32'h89AB_CDEF, 1'b1, 1'b0);
        tick(3);

        bus.auto_en = 1'b1;
        tick(24);

        bus.auto_en = 1'b0;
        tick(3);
        bus.btn_next = 1'b1;
        tick(10);
        bus.btn_next = 1'b0;
        tick(6);

        bus.btn_next = 1'b1;
        tick(2);
        bus.btn_next = 1'b0;
        tick(6);
        bus.btn_next = 1'b1;
        tick(5);
        bus.btn_next = 1'b0;
        tick(8);

        bus.auto_en = 1'b1;
        capture(32'h1234_5678, 1'b0, 1'b1);
        tick(15);
        capture(32'hCAFE_F00D, 1'b1, 1'b1);
        tick(10);

        bus.cap = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.dina = $urandom;
            bus.ofa  = 1'($urandom);
            bus.zfa  = 1'($urandom);
            tick();
        end
        bus.cap = 1'b0;
        tick(4);

        run = 0;
        for (int i = 0; i < 600; i++) begin
            if (run == 0) begin
                bus.btn_next = ~bus.btn_next;
                run = $urandom_range(1, 8);
            end
            run--;
            bus.cap  = ($urandom_range(0, 7) == 0);
            bus.dina = $urandom;
            bus.ofa  = 1'($urandom);
            bus.zfa  = 1'($urandom);
            if ($urandom_range(0, 39) == 0)
                bus.auto_en = ~bus.auto_en;
            rst = (i == 300 || i == 301);
            tick();
        end
        rst          = 1'b0;
        bus.cap      = 1'b0;
        bus.btn_next = 1'b0;
        tick(10);
        #1;
        chk("cap_q_drained", 32'(cap_q.size()), 32'd0);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/led_page_sequencer.md
# led_page_sequencer

Drives the byte/flag page select of the CPU's 8-LED result display. It latches a snapshot of the 32-bit ALU result and its overflow/zero flags, then presents the stored value through pages 0..4. The block steps the pages automatically on a dwell timer or manually on a push-button. It sits between the CPU datapath (result, flags, write strobe) and the LED byte-select mux on the board top level.

## Interface
- DWELL_CYCLES, 50_000_000: clock cycles each page is shown in auto mode; must be ≥ 2.
- DEB_CYCLES, 1_000_000: consecutive stable-high cycles required on the button; used only with debounce compiled in.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- dina  input  32  ALU result from the CPU.
- ofa  input  1  overflow flag.
- zfa  input  1  zero flag.
- cap  input  1  one-cycle strobe requesting a snapshot of dina/ofa/zfa.
- auto_en  input  1  level; 1 selects auto-scan, 0 selects manual.
- btn_next  input  1  raw, asynchronous push-button; a press advances the page.
- dout  output  32  snapshot result, fed to the mux data input.
- of_out  output  1  snapshot overflow flag.
- zf_out  output  1  snapshot zero flag.
- sela  output  3  page select: 0..3 = result byte 0..3, 4 = flags page.
- cap_ack  output  1  one-cycle pulse confirming a capture.

## Operation
- Reset values: dout=0, of_out=0, zf_out=0, sela=0, cap_ack=0, dwell counter=0, state=MANUAL, button synchronizer and debounce registers=0.
- The FSM has two states, MANUAL and AUTO. Each cycle the next state is AUTO if auto_en=1, else MANUAL. A mode change clears the dwell counter and leaves sela unchanged.
- Page advance: sela goes 0→1→2→3→4→0. sela never takes values 5..7.
- AUTO:
  - The dwell counter increments every cycle.
  - When it reaches DWELL_CYCLES-1, sela advances and the counter returns to 0.
  - A button advance also advances sela and clears the counter.
- MANUAL: the dwell counter is held at 0. Only button advances change sela.
- Capture: cap=1 at edge N loads dout←dina, of_out←ofa, zf_out←zfa, sela←0, and clears the dwell counter, all at edge N. cap_ack=1 for the cycle after edge N.
- Back-to-back cap on consecutive cycles: each one captures and produces its own ack, so cap_ack stays high continuously.
- Simultaneous events:
  - cap together with a button advance or dwell expiry: the capture wins and sela=0. The advance is dropped.
  - A button advance together with dwell expiry: sela advances by exactly one.
- Button conditioning: a 2-flop synchronizer, then edge detection. One press gives exactly one advance, regardless of how long the button is held.
- Counter width: ceil(log2(DWELL_CYCLES)) bits. The counter must not overflow for any legal parameter value.

## Timing
- Capture: outputs update at the same edge that samples cap=1. cap_ack is registered, one cycle later.
- Button without debounce: btn_next first sampled high at edge N → sela updates at edge N+2.
- Button with debounce: the synchronized level must be high for DEB_CYCLES consecutive cycles. sela updates at edge N+1+DEB_CYCLES. Any low sample restarts the count.
- Dwell: after a counter clear, sela advances on the DWELL_CYCLES-th subsequent edge.
- Reset mid-operation: rst=1 at an edge forces every reset value at that edge and overrides cap, the button and the timer. cap_ack is 0 during reset.

## Configuration
- LED_SEQ_DEBOUNCE_EN defined: the debounce counter is compiled in and DEB_CYCLES applies.
- LED_SEQ_DEBOUNCE_EN undefined: there is no debounce logic. Each synchronized rising edge is one press and DEB_CYCLES is ignored.

## Structure
- Shared package led_seq_pkg holds:
  - the page constants PAGE_B0=0, PAGE_B1=1, PAGE_B2=2, PAGE_B3=3, PAGE_FLAGS=4, PAGE_LAST=4;
  - the state encodings ST_MANUAL=0, ST_AUTO=1.
- Sub-module led_btn_cond contains the synchronizer, the optional debounce and the rising-edge pulse generator. Its output is a one-cycle press pulse.
- The top module holds the FSM, the dwell counter, the page register and the snapshot registers.

## Test plan
Bench parameters: DWELL_CYCLES=4, DEB_CYCLES=3.
1. Reset: hold rst for 2 cycles with cap and btn_next active → every output is 0, and sela=0 after release.
2. Capture: cap pulse with dina=32'h89AB_CDEF, ofa=1, zfa=0 → dout=32'h89AB_CDEF, of_out=1, zf_out=0, sela=0 at that edge, and cap_ack high for exactly the next cycle.
3. Auto scan: auto_en=1 and idle → sela advances every 4 edges through 0,1,2,3,4,0.
4. Manual press without debounce: auto_en=0, btn_next high for 10 cycles → exactly one advance (0→1), 2 edges after the first high sample.
5. Debounce build: a btn_next glitch of 2 cycles → no advance. A 5-cycle press → one advance, at edge N+4.
6. Collision: in AUTO with sela=3, cap asserted on the dwell-expiry edge → sela=0 and the counter is cleared. The next advance comes 4 edges later.
